// File: rtl/zx_keymatrix.sv
// PS/2 set-2 event to ZX Spectrum 8x5 keyboard matrix, with timed CAPS SHIFT combos for PC-only keys.
// Optional Sinclair-cursor joystick overlay enabled by defining KEYMATRIX_JOY_EN.
module zx_keymatrix #(
    parameter logic [15:0] COMBO_DELAY = 16'd56000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       kstrobe,
    input  logic       kpress,
    input  logic       kext,
    input  logic [7:0] kcode,
    input  logic [7:0] row,
`ifdef KEYMATRIX_JOY_EN
    input  logic [4:0] jstick,
`endif
    output logic [4:0] col
);

    localparam int unsigned ROWS  = 8;
    localparam int unsigned COLS  = 5;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned ID_W  = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COMBO_DELAY - 16'd1);

    typedef logic [ROWS-1:0][COLS-1:0] matrix_t;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD, ST_RELEASE} state_e;

    // {hit, row, col} for keys that map straight onto one matrix position
    function automatic logic [6:0] direct_map(input logic [8:0] k);
        logic [6:0] d;
        case (k)
            9'h012, 9'h059: d = {1'b1, 3'd0, 3'd0};
            9'h01A: d = {1'b1, 3'd0, 3'd1};
            9'h022: d = {1'b1, 3'd0, 3'd2};
            9'h021: d = {1'b1, 3'd0, 3'd3};
            9'h02A: d = {1'b1, 3'd0, 3'd4};
            9'h01C: d = {1'b1, 3'd1, 3'd0};
            9'h01B: d = {1'b1, 3'd1, 3'd1};
            9'h023: d = {1'b1, 3'd1, 3'd2};
            9'h02B: d = {1'b1, 3'd1, 3'd3};
            9'h034: d = {1'b1, 3'd1, 3'd4};
            9'h015: d = {1'b1, 3'd2, 3'd0};
            9'h01D: d = {1'b1, 3'd2, 3'd1};
            9'h024: d = {1'b1, 3'd2, 3'd2};
            9'h02D: d = {1'b1, 3'd2, 3'd3};
            9'h02C: d = {1'b1, 3'd2, 3'd4};
            9'h016: d = {1'b1, 3'd3, 3'd0};
            9'h01E: d = {1'b1, 3'd3, 3'd1};
            9'h026: d = {1'b1, 3'd3, 3'd2};
            9'h025: d = {1'b1, 3'd3, 3'd3};
            9'h02E: d = {1'b1, 3'd3, 3'd4};
            9'h045: d = {1'b1, 3'd4, 3'd0};
            9'h046: d = {1'b1, 3'd4, 3'd1};
            9'h03E: d = {1'b1, 3'd4, 3'd2};
            9'h03D: d = {1'b1, 3'd4, 3'd3};
            9'h036: d = {1'b1, 3'd4, 3'd4};
            9'h04D: d = {1'b1, 3'd5, 3'd0};
            9'h044: d = {1'b1, 3'd5, 3'd1};
            9'h043: d = {1'b1, 3'd5, 3'd2};
            9'h03C: d = {1'b1, 3'd5, 3'd3};
            9'h035: d = {1'b1, 3'd5, 3'd4};
            9'h05A: d = {1'b1, 3'd6, 3'd0};
            9'h04B: d = {1'b1, 3'd6, 3'd1};
            9'h042: d = {1'b1, 3'd6, 3'd2};
            9'h03B: d = {1'b1, 3'd6, 3'd3};
            9'h033: d = {1'b1, 3'd6, 3'd4};
            9'h029: d = {1'b1, 3'd7, 3'd0};
            9'h014, 9'h114: d = {1'b1, 3'd7, 3'd1};
            9'h03A: d = {1'b1, 3'd7, 3'd2};
            9'h031: d = {1'b1, 3'd7, 3'd3};
            9'h032: d = {1'b1, 3'd7, 3'd4};
            default: d = '0;
        endcase
        return d;
    endfunction

    // {hit, id} for PC-only keys synthesised as CAPS SHIFT + key
    function automatic logic [ID_W:0] combo_map(input logic [8:0] k);
        logic [ID_W:0] d;
        case (k)
            9'h066: d = {1'b1, 3'd0};
            9'h076: d = {1'b1, 3'd1};
            9'h16B: d = {1'b1, 3'd2};
            9'h172: d = {1'b1, 3'd3};
            9'h175: d = {1'b1, 3'd4};
            9'h174: d = {1'b1, 3'd5};
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic logic [5:0] combo_pos(input logic [ID_W-1:0] id);
        logic [5:0] p;
        case (id)
            3'd0:    p = {3'd4, 3'd0};
            3'd1:    p = {3'd7, 3'd0};
            3'd2:    p = {3'd3, 3'd4};
            3'd3:    p = {3'd4, 3'd4};
            3'd4:    p = {3'd4, 3'd3};
            3'd5:    p = {3'd4, 3'd2};
            default: p = '0;
        endcase
        return p;
    endfunction

    matrix_t          key_q, key_d;
    matrix_t          combo_m, joy_m;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  id_q, id_d;

    logic [6:0]       dk;
    logic [ID_W:0]    ck;
    logic [5:0]       cpos;
    logic             c_new, c_end;
    logic [COLS-1:0]  sel;

    always_comb begin
        dk = direct_map({kext, kcode});
        ck = combo_map({kext, kcode});
    end

    // Direct key image: each mapped event overwrites its bit with make/break
    always_comb begin
        key_d = key_q;
        if (kstrobe && dk[6]) begin
            key_d[dk[5:3]][dk[2:0]] = kpress;
        end
    end

    // Combo sequencer: a new combo make always restarts SHIFT, even mid-sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        c_new   = kstrobe && ck[ID_W] && kpress && ((state_q == ST_IDLE) || (ck[ID_W-1:0] != id_q));
        c_end   = kstrobe && ck[ID_W] && !kpress && (ck[ID_W-1:0] == id_q);
        if (c_new) begin
            state_d = ST_SHIFT;
            id_d    = ck[ID_W-1:0];
            cnt_d   = CNT_LOAD;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (c_end) begin
                        state_d = ST_RELEASE;
                        cnt_d   = CNT_LOAD;
                    end else if (cnt_q == '0) begin
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (c_end) begin
                        state_d = ST_RELEASE;
                        cnt_d   = CNT_LOAD;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_q   <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
        end else begin
            key_q   <= key_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
        end
    end

    // Combo contribution decoded from the registered sequencer state
    always_comb begin
        combo_m = '0;
        cpos    = combo_pos(id_q);
        if (state_q != ST_IDLE) begin
            combo_m[0][0] = 1'b1;
        end
        if (state_q == ST_HOLD) begin
            combo_m[cpos[5:3]][cpos[2:0]] = 1'b1;
        end
    end

`ifdef KEYMATRIX_JOY_EN
    logic [4:0] joy_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            joy_q <= '0;
        end else begin
            joy_q <= jstick;
        end
    end

    // Sinclair cursor layout: fire=0, up=7, down=6, left=5, right=8
    always_comb begin
        joy_m       = '0;
        joy_m[3][4] = joy_q[1];
        joy_m[4][4] = joy_q[2];
        joy_m[4][3] = joy_q[3];
        joy_m[4][2] = joy_q[0];
        joy_m[4][0] = joy_q[4];
    end
`else
    always_comb begin
        joy_m = '0;
    end
`endif

    // Every selected row pulls its pressed columns low, like the real diode matrix
    always_comb begin
        sel = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (!row[r]) begin
                sel = sel | key_q[r] | combo_m[r] | joy_m[r];
            end
        end
        col = ~sel;
    end

endmodule
